// File: rtl/param_block_memory_pkg.sv
// Shared defaults, state encoding and small helpers for the latency-configurable
// block memory that sits below the cache controller.
package param_block_memory_pkg;

    // Default geometry and timing of the main-memory model.
    localparam int MEMORY_BLOCK_SIZE = 128;
    localparam int MEMORY_ADDR_BITS  = 10;
    localparam int MEMORY_LATENCY    = 4;

    // Latency counter width; covers the full 1..255 latency range.
    localparam int CNT_W = 8;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    // Number of byte lanes in a block.
    function automatic int be_bits(input int block_bits);
        return block_bits / 8;
    endfunction

    // Counter preload so that the access lands exactly LATENCY edges after acceptance.
    function automatic logic [CNT_W-1:0] lat_preload(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/param_block_memory_mem_block_array.sv
// Synchronous single-port block array with per-byte write enables and a
// registered, write-first read port. Swappable for a vendor block RAM.
module mem_block_array
    import param_block_memory_pkg::*;
#(
    parameter  int BLOCK_BITS = MEMORY_BLOCK_SIZE,
    parameter  int ADDR_BITS  = MEMORY_ADDR_BITS,
    localparam int BE_BITS    = BLOCK_BITS / 8,
    localparam int DEPTH      = 2 ** ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [BLOCK_BITS-1:0] wdata,
    input  logic [BE_BITS-1:0]    be,
    output logic [BLOCK_BITS-1:0] rdata
);

    logic [BE_BITS-1:0][7:0] mem [DEPTH];
    logic [BE_BITS-1:0][7:0] wbytes;
    logic [BE_BITS-1:0][7:0] merged;
    logic [BE_BITS-1:0][7:0] rdata_q;

    assign wbytes = wdata;
    assign rdata  = rdata_q;

    // Post-write view of the addressed block: enabled bytes replaced, others kept.
    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < BE_BITS; i++) begin
            if (we && be[i]) merged[i] = wbytes[i];
        end
    end

    // Byte-granular array update; contents are never reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < BE_BITS; i++) begin
                if (be[i]) mem[addr][i] <= wbytes[i];
            end
        end
    end

    // Read register only moves on an access, so it holds through the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else if (en) rdata_q <= merged;
    end

endmodule

// File: rtl/param_block_memory.sv
// Main-memory block with a registered four-phase Req_Low/Rdy_Low handshake,
// programmable access latency and per-byte write enables.
module param_block_memory
    import param_block_memory_pkg::*;
#(
    parameter  int BLOCK_BITS = MEMORY_BLOCK_SIZE,
    parameter  int ADDR_BITS  = MEMORY_ADDR_BITS,
    parameter  int LATENCY    = MEMORY_LATENCY,
    localparam int BE_BITS    = BLOCK_BITS / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Req_Low,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [BLOCK_BITS-1:0] din,
    input  logic                  Wr,
    input  logic [BE_BITS-1:0]    be,
    output logic [BLOCK_BITS-1:0] dout,
    output logic                  Rdy_Low,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] LAT_INIT = lat_preload(LATENCY);

    // Request captured at acceptance; later input changes are ignored.
    typedef struct packed {
        logic                  wr;
        logic [ADDR_BITS-1:0]  addr;
        logic [BLOCK_BITS-1:0] din;
        logic [BE_BITS-1:0]    be;
    } mem_req_t;

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_d;
    logic             rdy_low_q, rdy_low_d;
    logic             busy_q, busy_d;
    logic             access;

    assign Rdy_Low = rdy_low_q;
    assign busy    = busy_q;

    // Handshake sequencing: accept, count down the latency, access, wait for release.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        rdy_low_d = rdy_low_q;
        busy_d    = busy_q;
        access    = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (!Req_Low) begin
                    req_d.wr   = Wr;
                    req_d.addr = addr;
                    req_d.din  = din;
                    req_d.be   = be;
                    cnt_d      = LAT_INIT;
                    busy_d     = 1'b1;
                    state_d    = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // Committed even if Req_Low was released early.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    access    = 1'b1;
                    rdy_low_d = 1'b0;
                    state_d   = MEM_DONE;
                end
            end
            MEM_DONE: begin
                // Rdy_Low stays low at least one cycle; released request returns to idle.
                if (Req_Low) begin
                    rdy_low_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = MEM_IDLE;
                end
            end
            default: begin
                rdy_low_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = MEM_IDLE;
            end
        endcase
    end

    // Control and request registers; reset drops any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MEM_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            rdy_low_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            rdy_low_q <= rdy_low_d;
            busy_q    <= busy_d;
        end
    end

    // The array's read register doubles as the dout output register.
    mem_block_array #(
        .BLOCK_BITS(BLOCK_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .en   (access),
        .we   (req_q.wr),
        .addr (req_q.addr),
        .wdata(req_q.din),
        .be   (req_q.be),
        .rdata(dout)
    );

endmodule

// File: tb/tb_param_block_memory.sv
// Bench for param_block_memory: four instances with latencies 4, 1, 2 and 7,
// directed handshake scenarios plus randomized traffic against a block model.
module tb_param_block_memory;

    localparam int ND = 4;

    function automatic int lat_of(input int d);
        case (d)
            0: return 4;
            1: return 1;
            2: return 2;
            default: return 7;
        endcase
    endfunction

    logic           clk = 1'b0;
    logic           rst;
    logic [ND-1:0]  req_low, wr, rdy_low, busy;
    logic [9:0]     addr [ND];
    logic [127:0]   din  [ND];
    logic [127:0]   dout [ND];
    logic [15:0]    be   [ND];

    logic [127:0]   mdl [ND][1024];
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        param_block_memory #(
            .BLOCK_BITS(128),
            .ADDR_BITS (10),
            .LATENCY   (lat_of(g))
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .Req_Low(req_low[g]),
            .addr   (addr[g]),
            .din    (din[g]),
            .Wr     (wr[g]),
            .be     (be[g]),
            .dout   (dout[g]),
            .Rdy_Low(rdy_low[g]),
            .busy   (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Block after a byte-masked write.
    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                           input logic [15:0] b);
        logic [127:0] r;
        r = old;
        for (int i = 0; i < 16; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // One full handshake on instance d, checking timing, dout and release.
    task automatic txn(input int d, input bit w, input logic [9:0] a, input logic [127:0] data,
                       input logic [15:0] b, input bit early, input bit scramble,
                       output logic [127:0] rd);
        logic [127:0] exp_v;
        int lat;
        lat   = lat_of(d);
        exp_v = w ? merge(mdl[d][a], data, b) : mdl[d][a];
        @(negedge clk);
        req_low[d] = 1'b0; wr[d] = w; addr[d] = a; din[d] = data; be[d] = b;
        @(posedge clk); #1;
        chk("accept_busy", busy[d], 1);
        chk("accept_rdy", rdy_low[d], 1);
        if (early) req_low[d] = 1'b1;
        for (int n = 1; n <= lat; n++) begin
            if (scramble) begin
                addr[d] = 10'($urandom);
                din[d]  = {$urandom, $urandom, $urandom, $urandom};
                be[d]   = 16'($urandom);
                wr[d]   = ~w;
            end
            @(posedge clk); #1;
            if (n < lat) chk("wait_rdy", rdy_low[d], 1);
            else         chk("latency_rdy", rdy_low[d], 0);
        end
        chk("dout", dout[d], exp_v);
        rd = dout[d];
        if (!early) begin
            @(posedge clk); #1;
            chk("hold_rdy", rdy_low[d], 0);
            chk("hold_dout", dout[d], exp_v);
            req_low[d] = 1'b1;
        end
        @(posedge clk); #1;
        chk("release_rdy", rdy_low[d], 1);
        chk("release_busy", busy[d], 0);
        if (w) mdl[d][a] = exp_v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rd, c_aa, c_55, c_one, pat, old20;
        c_aa  = {16{8'hAA}};
        c_55  = {16{8'h55}};
        c_one = {16{8'hFF}};
        pat   = 128'h0123456789ABCDEF0123456789ABCDEF;

        rst = 1'b1; req_low = '1; wr = '0;
        for (int d = 0; d < ND; d++) begin addr[d] = '0; din[d] = '0; be[d] = '0; end
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("reset_rdy", rdy_low[d], 1);
            chk("reset_busy", busy[d], 0);
            chk("reset_dout", dout[d], '0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Preload then read block 0x005.
        txn(0, 1, 10'h005, pat, 16'hFFFF, 0, 0, rd);
        txn(0, 0, 10'h005, '0, 16'h0000, 0, 0, rd);
        chk("read_005", rd, pat);

        // Masked write to 0x3FF.
        txn(0, 1, 10'h3FF, c_aa, 16'hFFFF, 0, 0, rd);
        txn(0, 1, 10'h3FF, c_55, 16'h00FF, 0, 0, rd);
        chk("masked_write_dout", rd, {c_aa[127:64], c_55[63:0]});
        txn(0, 0, 10'h3FF, '0, 16'hFFFF, 0, 0, rd);
        chk("masked_readback", rd, {c_aa[127:64], c_55[63:0]});

        // Write with no byte enables leaves the block alone.
        txn(0, 1, 10'h3FF, '0, 16'h0000, 0, 0, rd);
        chk("be0_dout", rd, {c_aa[127:64], c_55[63:0]});

        // Early release: one-cycle Rdy_Low pulse, write still performed.
        txn(0, 1, 10'h010, '0, 16'hFFFF, 0, 0, rd);
        txn(0, 1, 10'h010, c_one, 16'hFFFF, 1, 0, rd);
        txn(0, 0, 10'h010, '0, 16'h0000, 0, 0, rd);
        chk("early_readback", rd, c_one);

        // Inputs scrambled during WAIT.
        txn(0, 1, 10'h011, pat, 16'hF0F0, 0, 1, rd);
        txn(0, 0, 10'h005, '0, 16'h0000, 0, 1, rd);
        chk("scramble_read", rd, pat);

        // Reset while a write to 0x020 is in WAIT.
        old20 = 128'h11112222333344445555666677778888;
        txn(0, 1, 10'h020, old20, 16'hFFFF, 0, 0, rd);
        @(negedge clk);
        req_low[0] = 1'b0; wr[0] = 1'b1; addr[0] = 10'h020; din[0] = c_one; be[0] = 16'hFFFF;
        @(posedge clk); #1;
        req_low[0] = 1'b1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_wait_busy", busy[0], 0);
        chk("rst_wait_rdy", rdy_low[0], 1);
        @(negedge clk);
        rst = 1'b0;
        txn(0, 0, 10'h020, '0, 16'h0000, 0, 0, rd);
        chk("rst_wait_old", rd, old20);

        // Reset while in DONE: Rdy_Low releases immediately.
        @(negedge clk);
        req_low[0] = 1'b0; wr[0] = 1'b0; addr[0] = 10'h020;
        repeat (lat_of(0) + 1) @(posedge clk);
        #1;
        chk("pre_rst_done_rdy", rdy_low[0], 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_done_rdy", rdy_low[0], 1);
        chk("rst_done_busy", busy[0], 0);
        chk("rst_done_dout", dout[0], '0);
        req_low[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Latency sweep and random traffic on every instance.
        for (int d = 0; d < ND; d++) begin
            for (int j = 0; j < 8; j++)
                txn(d, 1, 10'h100 + 10'(j), {$urandom, $urandom, $urandom, $urandom},
                    16'hFFFF, 0, 0, rd);
            for (int t = 0; t < 20; t++)
                txn(d, 1'($urandom_range(0, 1)), 10'h100 + 10'($urandom_range(0, 7)),
                    {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
